// File: rtl/uart_transmitter.sv
// uart_transmitter: serial UART transmit stage.
// Frame format: one low start bit, 8 data bits LSB first, then STOP_BITS high stop bits.
// Each bit lasts CLKS_PER_BIT clocks. All outputs are registered.
// Optional feature: define UART_TX_HOLD_EN to add a one-byte holding register.
// With the holding register, a byte can be accepted while a frame is in flight.
// That byte then starts with no idle gap on the line.
module uart_transmitter #(
   parameter int CLKS_PER_BIT = 16,
   parameter int STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       rst,        // asynchronous, active low
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       tx_out,
   output logic       busy,
   output logic       ready,
   output logic       done
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t            r_state;
   logic [BAUD_W-1:0] r_baud_cnt;
   logic [2:0]        r_bit_cnt;
   logic              r_stop_cnt;
   logic [7:0]        r_shift;
   logic              r_tx_out;
   logic              r_busy;
   logic              r_ready;
   logic              r_done;

   state_t            w_state_next;
   logic [BAUD_W-1:0] w_baud_next;
   logic [2:0]        w_bit_next;
   logic              w_stop_next;
   logic [7:0]        w_shift_next;
   logic              w_tx_next;
   logic              w_busy_next;
   logic              w_ready_next;
   logic              w_done_next;

   logic              w_accept;
   logic              w_baud_end;
   logic              w_stop_last;
   logic              w_frame_end;
   logic              w_launch;
   logic [7:0]        w_launch_byte;

`ifdef UART_TX_HOLD_EN
   logic [7:0]        r_hold;
   logic              r_hold_full;
   logic [7:0]        w_hold_next;
   logic              w_hold_full_next;
`endif

   assign w_accept    = tx_start && r_ready;
   assign w_baud_end  = (r_baud_cnt == BAUD_LAST);
   // With a single stop bit, the first stop bit period is also the last one.
   assign w_stop_last = (STOP_BITS == 1) ? 1'b1 : r_stop_cnt;

   // Next-state and next-output logic for the frame sequencer.
   always_comb begin
      w_state_next  = r_state;
      w_baud_next   = r_baud_cnt;
      w_bit_next    = r_bit_cnt;
      w_stop_next   = r_stop_cnt;
      w_shift_next  = r_shift;
      w_tx_next     = r_tx_out;
      w_busy_next   = r_busy;
      w_done_next   = 1'b0;
      w_ready_next  = r_ready;
      w_frame_end   = 1'b0;
      w_launch      = 1'b0;
      w_launch_byte = tx_data;
`ifdef UART_TX_HOLD_EN
      w_hold_next      = r_hold;
      w_hold_full_next = r_hold_full;
`endif

      case (r_state)
         S_IDLE: begin
            w_tx_next   = 1'b1;
            w_busy_next = 1'b0;
         end
         S_START: begin
            if (w_baud_end) begin
               w_state_next = S_DATA;
               w_baud_next  = '0;
               w_bit_next   = 3'd0;
               w_tx_next    = r_shift[0];
            end else begin
               w_baud_next = r_baud_cnt + BAUD_W'(1);
            end
         end
         S_DATA: begin
            if (w_baud_end) begin
               w_baud_next = '0;
               if (r_bit_cnt == 3'd7) begin
                  w_state_next = S_STOP;
                  w_stop_next  = 1'b0;
                  w_tx_next    = 1'b1;
               end else begin
                  w_bit_next   = r_bit_cnt + 3'd1;
                  w_shift_next = {1'b0, r_shift[7:1]};
                  w_tx_next    = r_shift[1];
               end
            end else begin
               w_baud_next = r_baud_cnt + BAUD_W'(1);
            end
         end
         S_STOP: begin
            if (w_baud_end) begin
               w_baud_next = '0;
               if (w_stop_last) begin
                  w_frame_end  = 1'b1;
                  w_done_next  = 1'b1;
                  w_state_next = S_IDLE;
                  w_tx_next    = 1'b1;
                  w_busy_next  = 1'b0;
               end else begin
                  w_stop_next = 1'b1;
               end
            end else begin
               w_baud_next = r_baud_cnt + BAUD_W'(1);
            end
         end
         default: begin
            w_state_next = S_IDLE;
            w_tx_next    = 1'b1;
            w_busy_next  = 1'b0;
         end
      endcase

`ifdef UART_TX_HOLD_EN
      // A held byte has priority at the end of a frame.
      // A fresh request starts a frame directly when the line is free.
      // Otherwise, a fresh request is parked in the holding register.
      if (w_frame_end && r_hold_full) begin
         w_launch         = 1'b1;
         w_launch_byte    = r_hold;
         w_hold_full_next = 1'b0;
      end else if (w_accept) begin
         if ((r_state == S_IDLE) || w_frame_end) begin
            w_launch = 1'b1;
         end else begin
            w_hold_next      = tx_data;
            w_hold_full_next = 1'b1;
         end
      end
`else
      // Without holding, ready is only high in IDLE, so any accept starts a frame.
      if (w_accept) begin
         w_launch = 1'b1;
      end
`endif

      if (w_launch) begin
         w_state_next = S_START;
         w_baud_next  = '0;
         w_bit_next   = 3'd0;
         w_stop_next  = 1'b0;
         w_shift_next = w_launch_byte;
         w_tx_next    = 1'b0;
         w_busy_next  = 1'b1;
      end

`ifdef UART_TX_HOLD_EN
      w_ready_next = !w_hold_full_next;
`else
      w_ready_next = (w_state_next == S_IDLE);
`endif
   end

   // State, counters and registered outputs; reset forces the line high at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_baud_cnt <= '0;
         r_bit_cnt  <= 3'd0;
         r_stop_cnt <= 1'b0;
         r_shift    <= 8'h00;
         r_tx_out   <= 1'b1;
         r_busy     <= 1'b0;
         r_ready    <= 1'b1;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_baud_cnt <= w_baud_next;
         r_bit_cnt  <= w_bit_next;
         r_stop_cnt <= w_stop_next;
         r_shift    <= w_shift_next;
         r_tx_out   <= w_tx_next;
         r_busy     <= w_busy_next;
         r_ready    <= w_ready_next;
         r_done     <= w_done_next;
      end
   end

`ifdef UART_TX_HOLD_EN
   // Holding register and its full flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hold      <= 8'h00;
         r_hold_full <= 1'b0;
      end else begin
         r_hold      <= w_hold_next;
         r_hold_full <= w_hold_full_next;
      end
   end
`endif

   assign tx_out = r_tx_out;
   assign busy   = r_busy;
   assign ready  = r_ready;
   assign done   = r_done;

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: self-checking bench for uart_transmitter in its default build.
// Two instances are exercised: the default timing (16 clocks per bit, 1 stop bit)
// and a short one (3 clocks per bit, 2 stop bits).
// A frame-level reference model predicts the line level, busy, ready and done
// from the number of cycles elapsed since the accepting edge.
module tb_uart_transmitter;

   localparam int C_A = 16;
   localparam int S_A = 1;
   localparam int C_B = 3;
   localparam int S_B = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_a, start_b;
   logic [7:0] data_a, data_b;
   logic       tx_a, busy_a, ready_a, done_a;
   logic       tx_b, busy_b, ready_b, done_b;

   always #5 clk = ~clk;

   uart_transmitter #(.CLKS_PER_BIT(C_A), .STOP_BITS(S_A)) u_dut_a (
      .clk      (clk),
      .rst      (rst),
      .tx_start (start_a),
      .tx_data  (data_a),
      .tx_out   (tx_a),
      .busy     (busy_a),
      .ready    (ready_a),
      .done     (done_a)
   );

   uart_transmitter #(.CLKS_PER_BIT(C_B), .STOP_BITS(S_B)) u_dut_b (
      .clk      (clk),
      .rst      (rst),
      .tx_start (start_b),
      .tx_data  (data_b),
      .tx_out   (tx_b),
      .busy     (busy_b),
      .ready    (ready_b),
      .done     (done_b)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state, one entry per instance.
   bit         m_active [2];
   int         m_t      [2];
   logic [7:0] m_byte   [2];
   logic [7:0] m_rx     [2];
   bit         m_done   [2];
   int         n_frames [2];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int cpb(input int s);
      return (s == 0) ? C_A : C_B;
   endfunction

   function automatic int stops(input int s);
      return (s == 0) ? S_A : S_B;
   endfunction

   // Expected line level: start bit, 8 data bits LSB first, stop bits, idle high.
   function automatic logic exp_tx(input int s);
      int c;
      int t;
      c = cpb(s);
      t = m_t[s];
      if (!m_active[s]) return 1'b1;
      if (t < c) return 1'b0;
      if (t < 9 * c) return m_byte[s][t / c - 1];
      return 1'b1;
   endfunction

   task automatic check_outputs(input int s);
      logic  o_tx, o_busy, o_ready, o_done;
      string p;
      int    c;
      int    t;
      p       = (s == 0) ? "A" : "B";
      o_tx    = (s == 0) ? tx_a    : tx_b;
      o_busy  = (s == 0) ? busy_a  : busy_b;
      o_ready = (s == 0) ? ready_a : ready_b;
      o_done  = (s == 0) ? done_a  : done_b;
      check({p, ".tx_out"}, o_tx, exp_tx(s));
      check({p, ".busy"}, o_busy, m_active[s]);
      check({p, ".ready"}, o_ready, !m_active[s]);
      check({p, ".done"}, o_done, m_done[s]);
      // Independent mid-bit decoder: rebuild the byte from the line itself.
      c = cpb(s);
      t = m_t[s];
      if (m_active[s] && t >= c && t < 9 * c && (t % c) == c / 2)
         m_rx[s][t / c - 1] = o_tx;
      if (m_done[s]) begin
         check({p, ".rx_byte"}, m_rx[s], m_byte[s]);
         n_frames[s]++;
      end
   endtask

   // One clock cycle on instance s: drive inputs, advance the model, then check outputs.
   task automatic cycle(input int s, input bit start, input logic [7:0] data);
      if (s == 0) begin
         start_a = start;
         data_a  = data;
      end else begin
         start_b = start;
         data_b  = data;
      end
      @(posedge clk);
      m_done[s] = 1'b0;
      if (!m_active[s]) begin
         if (start) begin
            m_active[s] = 1'b1;
            m_t[s]      = 0;
            m_byte[s]   = data;
            m_rx[s]     = 8'h00;
         end
      end else begin
         m_t[s]++;
         if (m_t[s] == (9 + stops(s)) * cpb(s)) begin
            m_active[s] = 1'b0;
            m_done[s]   = 1'b1;
         end
      end
      #1;
      check_outputs(s);
   endtask

   task automatic model_reset();
      for (int s = 0; s < 2; s++) begin
         m_active[s] = 1'b0;
         m_t[s]      = 0;
         m_done[s]   = 1'b0;
      end
   endtask

   task automatic check_idle_both(input string tag);
      check({tag, ".A.tx_out"}, tx_a, 1'b1);
      check({tag, ".A.busy"}, busy_a, 1'b0);
      check({tag, ".A.ready"}, ready_a, 1'b1);
      check({tag, ".A.done"}, done_a, 1'b0);
      check({tag, ".B.tx_out"}, tx_b, 1'b1);
      check({tag, ".B.busy"}, busy_b, 1'b0);
   endtask

   initial begin
      rst     = 1'b0;
      start_a = 1'b0;
      start_b = 1'b0;
      data_a  = 8'h00;
      data_b  = 8'h00;
      model_reset();
      n_frames[0] = 0;
      n_frames[1] = 0;

      // Reset held with tx_start toggling: outputs stay at their idle values.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         start_a = i[0];
         start_b = i[0];
         data_a  = 8'(i * 37);
         @(posedge clk);
         #1;
         check_idle_both("reset");
      end
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      rst     = 1'b1;
      for (int i = 0; i < 20; i++) cycle(0, 1'b0, 8'h00);

      // Directed frame 0xA5.
      cycle(0, 1'b1, 8'hA5);
      for (int i = 0; i < 170; i++) cycle(0, 1'b0, 8'h00);

      // Start request during a 0x00 frame is ignored.
      for (int i = 0; i < 175; i++) cycle(0, (i == 0) || (i == 50), (i == 50) ? 8'hFF : 8'h00);

      // tx_start held high: frames run back to back at the earliest legal accept.
      for (int i = 0; i < 340; i++) cycle(0, 1'b1, 8'(8'h3C + i));
      for (int i = 0; i < 170; i++) cycle(0, 1'b0, 8'h00);

      // Reset during data bit 3 of 0x3C: line goes high at once, no done.
      cycle(0, 1'b1, 8'h3C);
      for (int i = 0; i < 400 && m_t[0] < 4 * C_A + 5; i++) cycle(0, 1'b0, 8'h00);
      #2;
      rst = 1'b0;
      #1;
      check("midrst.tx_out", tx_a, 1'b1);
      check("midrst.busy", busy_a, 1'b0);
      check("midrst.done", done_a, 1'b0);
      model_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_idle_both("midrst_hold");
      end
      rst = 1'b1;
      for (int i = 0; i < 5; i++) cycle(0, 1'b0, 8'h00);
      cycle(0, 1'b1, 8'h3C);
      for (int i = 0; i < 170; i++) cycle(0, 1'b0, 8'h00);

      // Loopback bytes.
      for (int b = 0; b < 4; b++) begin
         logic [31:0] lb;
         lb = 32'hFF00C33C;
         cycle(0, 1'b1, lb[8*b +: 8]);
         for (int i = 0; i < 165; i++) cycle(0, 1'b0, 8'h00);
      end

      // Random traffic on the default instance.
      for (int i = 0; i < 1500; i++) cycle(0, ($urandom_range(0, 7) == 0), 8'($urandom));
      for (int i = 0; i < 170; i++) cycle(0, 1'b0, 8'h00);

      // Short-bit, two-stop-bit instance: directed then random.
      cycle(1, 1'b1, 8'hA5);
      for (int i = 0; i < 40; i++) cycle(1, 1'b0, 8'h00);
      for (int i = 0; i < 100; i++) cycle(1, 1'b1, 8'(8'hC3 ^ i));
      for (int i = 0; i < 800; i++) cycle(1, ($urandom_range(0, 3) == 0), 8'($urandom));
      for (int i = 0; i < 40; i++) cycle(1, 1'b0, 8'h00);

      check("A.frames_seen", (n_frames[0] > 10) ? 1 : 0, 1);
      check("B.frames_seen", (n_frames[1] > 10) ? 1 : 0, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
